// File: rtl/run_length_unit_pkg.sv
// Shared definitions for the bit-run analyser.
// Holds the mode encodings, the FSM state codes and the mode-to-target-bit helper.
package run_length_unit_pkg;

    // Operation selected by the 2-bit mode input.
    typedef enum logic [1:0] {
        CAL_MAXONE  = 2'b00,   // longest run of ones
        CAL_MAXZERO = 2'b01,   // longest run of zeros
        CAL_RUNCNT  = 2'b10,   // number of runs of ones
        CAL_POPCNT  = 2'b11    // number of ones
    } cal_mode_e;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } rlu_state_e;

    // Bit value whose runs are measured: zeros only for the max-zero-run mode.
    function automatic logic target_bit(input cal_mode_e m);
        logic t;
        case (m)
            CAL_MAXZERO: t = 1'b0;
            CAL_MAXONE:  t = 1'b1;
            CAL_RUNCNT:  t = 1'b1;
            CAL_POPCNT:  t = 1'b1;
            default:     t = 1'b1;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/run_length_unit_scan_step.sv
// run_scan_step: combinational update of the run statistics for one STEP-bit slice.
// Bits are consumed LSB first so a run that spans slices keeps growing via cur/prev.
// Ports:
//   slice             STEP bits of the operand to consume this beat
//   target            bit value whose runs are tracked by cur/max
//   cur_in/cur_out    length of the current target run
//   max_in/max_out    longest target run seen so far
//   cnt_in/cnt_out    number of ones-runs started so far
//   pop_in/pop_out    number of ones seen so far
//   prev_in/prev_out  last bit consumed (0 before the first bit)
module run_scan_step #(
    parameter int STEP  = 4,
    parameter int CNT_W = 6
) (
    input  logic [STEP-1:0]  slice,
    input  logic             target,
    input  logic [CNT_W-1:0] cur_in,
    input  logic [CNT_W-1:0] max_in,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic [CNT_W-1:0] pop_in,
    input  logic             prev_in,
    output logic [CNT_W-1:0] cur_out,
    output logic [CNT_W-1:0] max_out,
    output logic [CNT_W-1:0] cnt_out,
    output logic [CNT_W-1:0] pop_out,
    output logic             prev_out
);

    logic [CNT_W-1:0] cur_s;
    logic [CNT_W-1:0] max_s;
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] pop_s;
    logic             prev_s;

    // Walk the slice bit by bit, chaining the running statistics.
    always_comb begin
        cur_s  = cur_in;
        max_s  = max_in;
        cnt_s  = cnt_in;
        pop_s  = pop_in;
        prev_s = prev_in;
        for (int i = 0; i < STEP; i++) begin
            if (slice[i] == target) begin
                cur_s = cur_s + CNT_W'(1'b1);
            end else begin
                cur_s = {CNT_W{1'b0}};
            end
            if (cur_s > max_s) begin
                max_s = cur_s;
            end else begin
                max_s = max_s;
            end
            // A ones-run starts on a 0->1 transition.
            cnt_s  = cnt_s + CNT_W'(slice[i] & ~prev_s);
            pop_s  = pop_s + CNT_W'(slice[i]);
            prev_s = slice[i];
        end
        cur_out  = cur_s;
        max_out  = max_s;
        cnt_out  = cnt_s;
        pop_out  = pop_s;
        prev_out = prev_s;
    end

endmodule

// File: rtl/run_length_unit.sv
// run_length_unit: multi-cycle bit-run analyser with start/busy handshake.
// Scans a WIDTH-bit operand STEP bits per cycle, LSB first, over N = WIDTH/STEP beats.
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-high reset, aborts any scan
//   start   request, accepted only in IDLE or DONE
//   mode    00 max ones-run, 01 max zeros-run, 10 ones-run count, 11 popcount
//   data    operand, sampled with an accepted start
//   busy    high during the N scan cycles
//   done    one-cycle pulse, result valid in the same cycle
//   result  last completed result, held until the next completion
module run_length_unit
    import run_length_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result
);

    localparam int BEATS  = WIDTH / STEP;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    rlu_state_e        state_r;
    rlu_state_e        state_next_s;
    cal_mode_e         mode_r;
    logic [WIDTH-1:0]  shift_r;
    logic [BEAT_W-1:0] beat_r;
    logic [CNT_W-1:0]  cur_r;
    logic [CNT_W-1:0]  max_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  pop_r;
    logic              prev_r;
    logic              busy_r;
    logic              done_r;
    logic [CNT_W-1:0]  result_r;

    logic              load_s;
    logic              last_beat_s;
    logic [CNT_W-1:0]  cur_s;
    logic [CNT_W-1:0]  max_s;
    logic [CNT_W-1:0]  cnt_s;
    logic [CNT_W-1:0]  pop_s;
    logic              prev_s;
    logic [CNT_W-1:0]  final_s;

    assign last_beat_s = (beat_r == BEAT_W'(BEATS - 1));

    run_scan_step #(
        .STEP  (STEP),
        .CNT_W (CNT_W)
    ) u_step (
        .slice    (shift_r[STEP-1:0]),
        .target   (target_bit(mode_r)),
        .cur_in   (cur_r),
        .max_in   (max_r),
        .cnt_in   (cnt_r),
        .pop_in   (pop_r),
        .prev_in  (prev_r),
        .cur_out  (cur_s),
        .max_out  (max_s),
        .cnt_out  (cnt_s),
        .pop_out  (pop_s),
        .prev_out (prev_s)
    );

    // Next-state logic; load_s marks an accepted start.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SCAN;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SCAN: begin
                if (last_beat_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SCAN;
                end
            end
            DONE: begin
                // Back-to-back: a start here skips IDLE.
                if (start) begin
                    state_next_s = SCAN;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
                load_s       = 1'b0;
            end
        endcase
    end

    // Pick the statistic that the latched mode asks for, including the final slice.
    always_comb begin
        final_s = max_s;
        case (mode_r)
            CAL_MAXONE:  final_s = max_s;
            CAL_MAXZERO: final_s = max_s;
            CAL_RUNCNT:  final_s = cnt_s;
            CAL_POPCNT:  final_s = pop_s;
            default:     final_s = max_s;
        endcase
    end

    // State, datapath and output registers; busy/done are registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            mode_r   <= CAL_MAXONE;
            shift_r  <= {WIDTH{1'b0}};
            beat_r   <= {BEAT_W{1'b0}};
            cur_r    <= {CNT_W{1'b0}};
            max_r    <= {CNT_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            pop_r    <= {CNT_W{1'b0}};
            prev_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == SCAN);
            done_r  <= (state_next_s == DONE);
            if (load_s) begin
                shift_r <= data;
                mode_r  <= cal_mode_e'(mode);
                beat_r  <= {BEAT_W{1'b0}};
                cur_r   <= {CNT_W{1'b0}};
                max_r   <= {CNT_W{1'b0}};
                cnt_r   <= {CNT_W{1'b0}};
                pop_r   <= {CNT_W{1'b0}};
                prev_r  <= 1'b0;
            end else if (state_r == SCAN) begin
                shift_r <= shift_r >> STEP;
                beat_r  <= beat_r + BEAT_W'(1'b1);
                cur_r   <= cur_s;
                max_r   <= max_s;
                cnt_r   <= cnt_s;
                pop_r   <= pop_s;
                prev_r  <= prev_s;
                if (last_beat_s) begin
                    result_r <= final_s;
                end else begin
                    result_r <= result_r;
                end
            end else begin
                shift_r <= shift_r;
                beat_r  <= beat_r;
            end
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_run_length_unit.sv
// Directed bench for run_length_unit plus a random cross-check of several STEP values.
module tb_run_length_unit;

    logic        clk;
    logic        reset;

    // Main instance: WIDTH=32, STEP=4
    logic        start;
    logic [1:0]  mode;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic [5:0]  result;

    // Narrow instance: WIDTH=8, STEP=1
    logic        start8;
    logic [1:0]  mode8;
    logic [7:0]  data8;
    logic        busy8;
    logic        done8;
    logic [3:0]  result8;

    // Random-compare instances: WIDTH=32, STEP = 1, 2, 8, 32
    logic        rstart;
    logic [1:0]  rmode;
    logic [31:0] rdata;
    logic [3:0]  rbusy;
    logic [3:0]  rdone;
    logic [5:0]  rres0, rres1, rres2, rres3;

    int n_cmp = 0;
    int n_bad = 0;

    run_length_unit #(.WIDTH(32), .STEP(4)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .data(data),
        .busy(busy), .done(done), .result(result));

    run_length_unit #(.WIDTH(8), .STEP(1)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .mode(mode8), .data(data8),
        .busy(busy8), .done(done8), .result(result8));

    run_length_unit #(.WIDTH(32), .STEP(1)) dut_s1 (
        .clk(clk), .reset(reset), .start(rstart), .mode(rmode), .data(rdata),
        .busy(rbusy[0]), .done(rdone[0]), .result(rres0));
    run_length_unit #(.WIDTH(32), .STEP(2)) dut_s2 (
        .clk(clk), .reset(reset), .start(rstart), .mode(rmode), .data(rdata),
        .busy(rbusy[1]), .done(rdone[1]), .result(rres1));
    run_length_unit #(.WIDTH(32), .STEP(8)) dut_s8 (
        .clk(clk), .reset(reset), .start(rstart), .mode(rmode), .data(rdata),
        .busy(rbusy[2]), .done(rdone[2]), .result(rres2));
    run_length_unit #(.WIDTH(32), .STEP(32)) dut_s32 (
        .clk(clk), .reset(reset), .start(rstart), .mode(rmode), .data(rdata),
        .busy(rbusy[3]), .done(rdone[3]), .result(rres3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: walks the operand bit by bit.
    function automatic int model(input logic [31:0] d, input logic [1:0] m);
        int best = 0;
        int run = 0;
        int runs = 0;
        int ones = 0;
        logic t;
        logic p;
        t = (m == 2'b01) ? 1'b0 : 1'b1;
        p = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (d[i] == t) begin
                run++;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
            if (d[i] == 1'b1) ones++;
            if (d[i] == 1'b1 && p == 1'b0) runs++;
            p = d[i];
        end
        case (m)
            2'b10:   return runs;
            2'b11:   return ones;
            default: return best;
        endcase
    endfunction

    // Start one operation on the main instance; lat counts edges from the accepting edge.
    task automatic run_main(input logic [31:0] d, input logic [1:0] m,
                            output int res, output int lat, output int bcnt);
        data  = d;
        mode  = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat  = 1;
        bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        check_eq("done_seen", int'(done), 1);
        check_eq("busy_in_done", int'(busy), 0);
        res = int'(result);
    endtask

    logic [31:0] vd [8] = '{32'h03F80F50, 32'h03F80F50, 32'h03F80F50, 32'h03F80F50,
                            32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hAAAAAAAA};
    logic [1:0]  vm [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b00, 2'b10};
    int          ve [8] = '{7, 7, 4, 13, 32, 32, 0, 16};

    initial begin
        int res, lat, bcnt, pulses;
        int   rexp;
        int   got [4];
        logic seen [4];

        reset = 1'b1;
        start = 1'b0; mode = 2'b00; data = 32'h0;
        start8 = 1'b0; mode8 = 2'b00; data8 = 8'h0;
        rstart = 1'b0; rmode = 2'b00; rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_result", int'(result), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed vectors on the main instance
        for (int i = 0; i < 8; i++) begin
            run_main(vd[i], vm[i], res, lat, bcnt);
            check_eq($sformatf("vec%0d_result", i), res, ve[i]);
            check_eq($sformatf("vec%0d_latency", i), lat, 9);
            check_eq($sformatf("vec%0d_busy_cycles", i), bcnt, 8);
            @(posedge clk); #1;
            check_eq($sformatf("vec%0d_done_pulse", i), int'(done), 0);
            check_eq($sformatf("vec%0d_result_held", i), int'(result), ve[i]);
        end

        // start held through SCAN with new data/mode: ignored; then accepted in DONE
        data = 32'h03F80F50; mode = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        data = 32'h0F0F0000; mode = 2'b10;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("hold_first_latency", lat, 9);
        check_eq("hold_first_result", int'(result), 7);
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        check_eq("b2b_busy", int'(busy), 1);
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("b2b_latency", lat, 9);
        check_eq("b2b_result", int'(result), 2);
        @(posedge clk); #1;

        // Reset during beat 3 aborts the scan
        data = 32'h03F80F50; mode = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("pre_abort_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_result", int'(result), 0);
        check_eq("abort_done", int'(done), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        check_eq("abort_no_done", pulses, 0);
        run_main(32'h03F80F50, 2'b01, res, lat, bcnt);
        check_eq("after_abort_result", res, 7);
        check_eq("after_abort_latency", lat, 9);

        // Narrow instance, WIDTH=8 STEP=1
        data8 = 8'b0111_0110; mode8 = 2'b00; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 1;
        while (done8 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("w8_latency", lat, 9);
        check_eq("w8_result", int'(result8), 3);

        // Random compare across STEP = 1, 2, 8, 32
        for (int n = 0; n < 20; n++) begin
            rdata = (n == 0) ? 32'hFFFFFFFF : (n == 1) ? 32'h00000000 : $urandom;
            rmode = (n == 1) ? 2'b01 : 2'(n % 4);
            rexp  = model(rdata, rmode);
            for (int k = 0; k < 4; k++) begin
                seen[k] = 1'b0;
                got[k]  = -1;
            end
            rstart = 1'b1;
            @(posedge clk); #1;
            rstart = 1'b0;
            for (int c = 0; c < 36; c++) begin
                if (rdone[0] === 1'b1 && !seen[0]) begin seen[0] = 1'b1; got[0] = int'(rres0); end
                if (rdone[1] === 1'b1 && !seen[1]) begin seen[1] = 1'b1; got[1] = int'(rres1); end
                if (rdone[2] === 1'b1 && !seen[2]) begin seen[2] = 1'b1; got[2] = int'(rres2); end
                if (rdone[3] === 1'b1 && !seen[3]) begin seen[3] = 1'b1; got[3] = int'(rres3); end
                @(posedge clk); #1;
            end
            for (int k = 0; k < 4; k++) begin
                check_eq($sformatf("rand%0d_step_idx%0d", n, k), got[k], rexp);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
